pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the write-enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three hazard classes:
- load-use data hazards;
- taken branches/jumps resolved in MEM;
- multi-cycle data-memory accesses, with a timeout.
Sits beside the datapath and is the sole source of pipeline-register enables.

Parameters:
WAIT_MAX, 16, max consecutive data-memory wait cycles before timeout (1..255)
CNT_W, 32, width of performance counters

Ports:
Clk  in  1  clock; all registers update on negedge, matching the pipeline registers
Rst  in  1  asynchronous active-high reset
ID_Rs  in  5  source reg 1 of instruction in ID
ID_Rt  in  5  source reg 2 of instruction in ID
ID_UsesRt  in  1  ID instruction reads Rt
EX_Rw  in  5  destination reg of instruction in EX
EX_RegWr  in  1  EX instruction writes a register
EX_MemtoReg  in  1  EX instruction is a load
MEM_PCSrc  in  1  branch/jump taken in MEM
MEM_Req  in  1  MEM instruction accesses data memory (MemWr or MemtoReg)
Mem_Ready  in  1  data memory completes access this cycle
PC_Wr  out  1  PC write enable
IF_ID_Wr  out  1  IF/ID write enable
IF_ID_Flush  out  1  IF/ID clear
ID_EX_Wr  out  1  ID/EX write enable
ID_EX_Flush  out  1  ID/EX clear (bubble)
EX_MEM_Wr  out  1  EX/MEM write enable
MEM_WB_Bubble  out  1  MEM/WB loads a bubble
Mem_Err  out  1  sticky memory-timeout error
Stall_Cnt  out  CNT_W  cycles with PC_Wr=0
Flush_Cnt  out  CNT_W  count of taken-branch flushes

Behaviour:
- State machine: RUN, MEM_WAIT, ERR. Reset to RUN with wait counter 0, Mem_Err=0 and both counters 0.
- Control outputs are combinational from state and inputs.
- Default (no hazard): all *_Wr=1, all flush/bubble outputs=0.
- Priority order: freeze, then branch flush, then load-use.
- Freeze applies when (RUN and MEM_Req and !Mem_Ready), in MEM_WAIT while !Mem_Ready, and always in ERR:
  - PC_Wr, IF_ID_Wr, ID_EX_Wr, EX_MEM_Wr all 0; MEM_WB_Bubble=1; flushes=0.
  - A MEM_PCSrc seen during freeze is not acted on. The MEM stage holds, so it is serviced on the release cycle.
- Branch flush applies when MEM_PCSrc and not frozen:
  - IF_ID_Flush=1, ID_EX_Flush=1, PC_Wr=1.
  - Load-use is suppressed in the same cycle.
  - Flush_Cnt increments.
- Load-use applies when EX_MemtoReg, EX_RegWr, EX_Rw!=0, and (EX_Rw==ID_Rs or (ID_UsesRt and EX_Rw==ID_Rt)), with no freeze and no branch flush:
  - PC_Wr=0, IF_ID_Wr=0, ID_EX_Flush=1.
  - Lasts exactly one cycle, because the load then leaves EX.
- Transitions:
  - RUN to MEM_WAIT on MEM_Req and !Mem_Ready; the wait counter loads 1.
  - In MEM_WAIT, Mem_Ready returns to RUN. That cycle is a release cycle: normal priority rules apply and the counter clears.
  - In MEM_WAIT, !Mem_Ready increments the wait counter. When the counter equals WAIT_MAX and Mem_Ready is still 0, go to ERR and set Mem_Err.
  - ERR exits only via Rst.
- Mem_Ready=1 in the same cycle MEM_Req rises: no stall, stay in RUN.
- Stall_Cnt increments on every edge where PC_Wr=0. Both counters saturate at all-ones (no wrap).
- Rst asserted mid-MEM_WAIT: immediate return to RUN, counters and Mem_Err cleared asynchronously.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: Stall_Cnt and Flush_Cnt are implemented as above.
- Undefined: no counter registers; both outputs are constant 0.
- Hazard behaviour is identical in both cases.

Test Plan:
- Reset: Rst=1 mid-run → all *_Wr=1, flushes=0, Mem_Err=0, counters 0 immediately (async).
- Load-use: EX_MemtoReg=1, EX_RegWr=1, EX_Rw=5, ID_Rs=5 → one cycle PC_Wr=0, IF_ID_Wr=0, ID_EX_Flush=1, Stall_Cnt=1. Repeat with EX_Rw=0, or ID_Rt=5 with ID_UsesRt=0 → no stall.
- Branch beats load-use: MEM_PCSrc=1 with load-use condition true → IF_ID_Flush=1, ID_EX_Flush=1, PC_Wr=1, Flush_Cnt=1.
- Memory wait: MEM_Req=1, Mem_Ready=0 for 3 cycles then 1 → 3 freeze cycles (EX_MEM_Wr=0, MEM_WB_Bubble=1), release on 4th, state RUN, Stall_Cnt=3.
- Branch during freeze: MEM_PCSrc=1 with memory stalled 2 cycles → no flush while frozen; flush on release cycle.
- Timeout: WAIT_MAX=4, Mem_Ready held 0 → Mem_Err=1 after 4 wait cycles, pipeline frozen indefinitely; Mem_Ready=1 later has no effect; Rst clears.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. It is the only
//   source of pipeline-register write enables and clears. It resolves, in
//   priority order:
//     1. memory freeze: multi-cycle data-memory access, with a timeout.
//     2. branch flush: taken branch/jump resolved in MEM.
//     3. load-use stall: a load in EX feeding a source register of ID.
//   All state updates on the falling edge of Clk, matching the pipeline
//   registers. Rst is asynchronous and active-high.
//
// Parameters
//   WAIT_MAX : max consecutive MEM_WAIT cycles before a timeout (1..255)
//   CNT_W    : width of the performance counters
//
// Ports
//   Clk, Rst                         clock (negedge active), async reset
//   ID_Rs, ID_Rt, ID_UsesRt          source operands of the ID instruction
//   EX_Rw, EX_RegWr, EX_MemtoReg     destination and kind of the EX instruction
//   MEM_PCSrc                        taken branch/jump in MEM
//   MEM_Req, Mem_Ready               data-memory request / completion
//   PC_Wr, IF_ID_Wr, ID_EX_Wr,
//   EX_MEM_Wr                        pipeline-register write enables
//   IF_ID_Flush, ID_EX_Flush         pipeline-register clears
//   MEM_WB_Bubble                    MEM/WB loads a bubble
//   Mem_Err                          sticky memory-timeout error
//   Stall_Cnt, Flush_Cnt             saturating perf counters
//
// Optional feature macro: PIPE_PERF_CNT_EN
//   defined   : Stall_Cnt / Flush_Cnt are live saturating counters
//   undefined : no counter registers, both outputs tie to 0
module pipe_hazard_ctrl #(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic [4:0]       EX_Rw,
    input  logic             EX_RegWr,
    input  logic             EX_MemtoReg,
    input  logic             MEM_PCSrc,
    input  logic             MEM_Req,
    input  logic             Mem_Ready,
    output logic             PC_Wr,
    output logic             IF_ID_Wr,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Wr,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Wr,
    output logic             MEM_WB_Bubble,
    output logic             Mem_Err,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       frozen;
    logic       branch;
    logic       load_use;
    logic       raw_hit;

    // ID reads the register the load in EX is about to produce.
    assign raw_hit = EX_MemtoReg && EX_RegWr && (EX_Rw != 5'd0) &&
                     ((EX_Rw == ID_Rs) || (ID_UsesRt && (EX_Rw == ID_Rt)));

    always_comb begin
        frozen = 1'b0;
        case (state)
            RUN:      frozen = MEM_Req && !Mem_Ready;
            MEM_WAIT: frozen = !Mem_Ready;
            default:  frozen = 1'b1;
        endcase
        // A branch seen while frozen is left in MEM and acted on at release.
        branch   = MEM_PCSrc && !frozen;
        load_use = raw_hit && !frozen && !branch;
    end

    assign PC_Wr         = !(frozen || load_use);
    assign IF_ID_Wr      = !(frozen || load_use);
    assign IF_ID_Flush   = branch;
    assign ID_EX_Wr      = !frozen;
    assign ID_EX_Flush   = branch || load_use;
    assign EX_MEM_Wr     = !frozen;
    assign MEM_WB_Bubble = frozen;

    // wait_cnt holds the number of wait cycles already spent; a MEM_WAIT
    // cycle that finds it at WAIT_MAX with memory still busy times out.
    always_ff @(negedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            Mem_Err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (MEM_Req && !Mem_Ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (Mem_Ready) begin
                        state    <= RUN;
                        wait_cnt <= 8'd0;
                    end else if (wait_cnt == 8'(WAIT_MAX)) begin
                        state   <= ERR;
                        Mem_Err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state   <= ERR;
                    Mem_Err <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(negedge Clk or posedge Rst) begin
        if (Rst) begin
            Stall_Cnt <= '0;
            Flush_Cnt <= '0;
        end else begin
            if (!PC_Wr && (Stall_Cnt != '1))
                Stall_Cnt <= Stall_Cnt + 1'b1;
            if (branch && (Flush_Cnt != '1))
                Flush_Cnt <= Flush_Cnt + 1'b1;
        end
    end
`else
    assign Stall_Cnt = '0;
    assign Flush_Cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// random stimulus, all compared against a behavioural model that tracks
// only "error seen" and "consecutive memory wait cycles so far".
module tb_pipe_hazard_ctrl;

    localparam int WAIT_MAX = 4;
    localparam int CNT_W    = 8;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic [4:0] rw;
        logic       reg_wr;
        logic       mem_to_reg;
        logic       pc_src;
        logic       req;
        logic       rdy;
    } stim_t;

    logic             Clk = 1'b0;
    logic             Rst = 1'b0;
    logic [4:0]       ID_Rs = '0, ID_Rt = '0, EX_Rw = '0;
    logic             ID_UsesRt = 0, EX_RegWr = 0, EX_MemtoReg = 0;
    logic             MEM_PCSrc = 0, MEM_Req = 0, Mem_Ready = 0;
    logic             PC_Wr, IF_ID_Wr, IF_ID_Flush, ID_EX_Wr, ID_EX_Flush;
    logic             EX_MEM_Wr, MEM_WB_Bubble, Mem_Err;
    logic [CNT_W-1:0] Stall_Cnt, Flush_Cnt;

    pipe_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst(Rst),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .EX_Rw(EX_Rw), .EX_RegWr(EX_RegWr), .EX_MemtoReg(EX_MemtoReg),
        .MEM_PCSrc(MEM_PCSrc), .MEM_Req(MEM_Req), .Mem_Ready(Mem_Ready),
        .PC_Wr(PC_Wr), .IF_ID_Wr(IF_ID_Wr), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Wr(ID_EX_Wr), .ID_EX_Flush(ID_EX_Flush), .EX_MEM_Wr(EX_MEM_Wr),
        .MEM_WB_Bubble(MEM_WB_Bubble), .Mem_Err(Mem_Err),
        .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // model state
    bit m_err   = 0;
    int m_wait  = 0;   // consecutive unserviced memory cycles so far
    int m_stall = 0;
    int m_flush = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {PC_Wr, IF_ID_Wr, IF_ID_Flush, ID_EX_Wr, ID_EX_Flush, EX_MEM_Wr, MEM_WB_Bubble}
    function automatic logic [6:0] model_ctl(input stim_t s, output bit frz, output bit br);
        bit lu;
        frz = m_err || (m_wait > 0 ? !s.rdy : (s.req && !s.rdy));
        br  = s.pc_src && !frz;
        lu  = s.mem_to_reg && s.reg_wr && s.rw != 0 &&
              (s.rw == s.rs || (s.uses_rt && s.rw == s.rt)) && !frz && !br;
        return {!(frz || lu), !(frz || lu), br, !frz, br || lu, !frz, frz};
    endfunction

    function automatic logic [6:0] dut_ctl();
        return {PC_Wr, IF_ID_Wr, IF_ID_Flush, ID_EX_Wr, ID_EX_Flush, EX_MEM_Wr, MEM_WB_Bubble};
    endfunction

    function automatic int perf(input int v);
        return PERF ? v : 0;
    endfunction

    task automatic check_all(input stim_t s, output bit frz, output bit br);
        logic [6:0] exp;
        exp = model_ctl(s, frz, br);
        chk("ctl", 32'(dut_ctl()), 32'(exp));
        chk("mem_err", 32'(Mem_Err), 32'(m_err));
        chk("stall_cnt", 32'(Stall_Cnt), 32'(perf(m_stall)));
        chk("flush_cnt", 32'(Flush_Cnt), 32'(perf(m_flush)));
    endtask

    // One clock: inputs change at posedge+1, outputs checked at posedge+3,
    // DUT state moves at the following negedge (posedge+5).
    task automatic cycle(input stim_t s, input bit do_rst);
        bit frz, br;
        @(posedge Clk);
        #1;
        {ID_Rs, ID_Rt, ID_UsesRt, EX_Rw, EX_RegWr, EX_MemtoReg,
         MEM_PCSrc, MEM_Req, Mem_Ready} = s;
        if (do_rst) begin
            Rst = 1'b1;
            m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0;
            #1;
            check_all(s, frz, br);
            Rst = 1'b0;
            #1;
        end else begin
            #2;
        end
        check_all(s, frz, br);
        if (!m_err) begin
            if (frz) begin
                if (m_wait == WAIT_MAX) m_err = 1;
                else m_wait++;
            end else begin
                m_wait = 0;
            end
        end
        if (!(model_ctl(s, frz, br) >> 6)) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
        if (br) m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
    endtask

    function automatic stim_t quiet();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t lu_stim(input logic [4:0] rw, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic urt);
        stim_t s;
        s = '0;
        s.rw = rw; s.rs = rs; s.rt = rt; s.uses_rt = urt;
        s.reg_wr = 1; s.mem_to_reg = 1;
        return s;
    endfunction

    function automatic stim_t mem_stim(input logic rdy, input logic pcs);
        stim_t s;
        s = '0;
        s.req = 1; s.rdy = rdy; s.pc_src = pcs;
        return s;
    endfunction

    initial begin
        stim_t s;
        int err_age;

        cycle(quiet(), 1);

        // load-use hit on Rs, then the two non-hazard variants
        cycle(lu_stim(5'd5, 5'd5, 5'd0, 1'b0), 0);
        chk("lu_ctl", 32'(dut_ctl()), 32'(7'b0001110));
        cycle(lu_stim(5'd0, 5'd0, 5'd0, 1'b1), 0);
        chk("lu_stall_cnt", 32'(Stall_Cnt), 32'(perf(1)));
        cycle(lu_stim(5'd5, 5'd1, 5'd5, 1'b0), 0);
        cycle(lu_stim(5'd5, 5'd1, 5'd5, 1'b1), 0);

        // branch beats load-use
        cycle(quiet(), 1);
        s = lu_stim(5'd5, 5'd5, 5'd0, 1'b0);
        s.pc_src = 1;
        cycle(s, 0);
        chk("br_ctl", 32'(dut_ctl()), 32'(7'b1111110));
        cycle(quiet(), 0);
        chk("br_flush_cnt", 32'(Flush_Cnt), 32'(perf(1)));

        // three-cycle memory wait then release
        cycle(quiet(), 1);
        repeat (3) cycle(mem_stim(1'b0, 1'b0), 0);
        cycle(mem_stim(1'b1, 1'b0), 0);
        cycle(quiet(), 0);
        chk("wait_stall_cnt", 32'(Stall_Cnt), 32'(perf(3)));

        // branch held during a two-cycle freeze is taken on release
        repeat (2) cycle(mem_stim(1'b0, 1'b1), 0);
        cycle(mem_stim(1'b1, 1'b1), 0);
        cycle(quiet(), 0);

        // reset arriving mid-wait returns to RUN immediately
        repeat (2) cycle(mem_stim(1'b0, 1'b0), 0);
        cycle(quiet(), 1);
        cycle(quiet(), 0);

        // timeout: error is sticky and ignores a later Mem_Ready
        repeat (WAIT_MAX + 3) cycle(mem_stim(1'b0, 1'b0), 0);
        chk("timeout_err", 32'(Mem_Err), 32'd1);
        repeat (3) cycle(mem_stim(1'b1, 1'b1), 0);
        cycle(quiet(), 1);

        // random traffic; hold the error long enough to saturate Stall_Cnt
        err_age = 0;
        for (int i = 0; i < 3000; i++) begin
            s.rs         = 5'($urandom_range(0, 3));
            s.rt         = 5'($urandom_range(0, 3));
            s.rw         = 5'($urandom_range(0, 3));
            s.uses_rt    = 1'($urandom_range(0, 1));
            s.reg_wr     = ($urandom_range(0, 3) != 0);
            s.mem_to_reg = 1'($urandom_range(0, 1));
            s.pc_src     = ($urandom_range(0, 6) == 0);
            s.req        = ($urandom_range(0, 4) < 2);
            s.rdy        = ($urandom_range(0, 9) < 6);
            err_age = m_err ? err_age + 1 : 0;
            cycle(s, err_age > ((i > 1500) ? 300 : 15));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
